// File: rtl/bidir_pkg.sv
// Shared types and constants for the bidirectional single-wire byte transceiver.
package bidir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX,
        TURN,
        RX_WAIT,
        RX_START,
        RX_SHIFT
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic BUS_IDLE  = 1'b1;
    localparam int   DATA_BITS = 8;
    localparam int   CNT_W     = 10;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/bidir_serial_xcvr_bit_timer.sv
// Bit-period down-counter shared by TX and RX; a half load makes the next tick land mid-bit.
module bidir_bit_timer #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic half_i,
    output logic tick_o
);
    import bidir_pkg::*;

    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);

    logic [CNT_W-1:0] cnt_q;

    // Free-running reload keeps consecutive bits exactly DIV cycles apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= FULL_M1;
        end else if (half_i) begin
            cnt_q <= HALF_M1;
        end else if (cnt_q == '0) begin
            cnt_q <= FULL_M1;
        end else begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/bidir_serial_xcvr.sv
// Half-duplex single-wire byte transceiver: one TX frame, bus turnaround, optional reply frame.
// Defining BIDIR_XCVR_PARITY_EN adds an even-parity bit after d[7] in both directions.
module bidir_serial_xcvr #(
    parameter int DIV     = 16,
    parameter int TURN    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       rx_expect,
    output logic       tx_ready,
    output logic       bus_oe,
    output logic       bus_out,
    input  logic       bus_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       timeout,
    output logic       busy
);
    import bidir_pkg::*;

    localparam int TO_W = $clog2(TIMEOUT) + 1;
    localparam logic [TO_W-1:0] TURN_M1 = TO_W'(TURN - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
`ifdef BIDIR_XCVR_PARITY_EN
    localparam logic [3:0] TX_STOP_IDX = 4'd10;
`else
    localparam logic [3:0] TX_STOP_IDX = 4'd9;
`endif

    state_t                 state_q;
    logic [1:0]             sync_q;
    logic                   rx_bit;
    logic [DATA_BITS-1:0]   data_q;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_expect_q;
    logic                   bus_oe_q;
    logic                   bus_out_q;
    logic                   bus_out_d;
    logic                   rx_valid_q;
    logic                   rx_err_q;
    logic                   timeout_q;
    logic [3:0]             bit_idx_q;
    logic [TO_W-1:0]        to_q;
    logic                   tmr_load;
    logic                   tmr_half;
    logic                   tmr_tick;
    logic                   rx_ok;
`ifdef BIDIR_XCVR_PARITY_EN
    logic                   par_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {2{BUS_IDLE}};
        end else begin
            sync_q <= {sync_q[0], bus_in};
        end
    end

    assign rx_bit   = sync_q[1];
    assign tmr_load = (state_q == IDLE) && tx_valid;
    assign tmr_half = (state_q == RX_WAIT) && !rx_bit;

    bidir_bit_timer #(
        .DIV(DIV)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load_i(tmr_load),
        .half_i(tmr_half),
        .tick_o(tmr_tick)
    );

    // Wire value for the bit that follows the one currently being driven.
    always_comb begin
        bus_out_d = STOP_BIT;
        if (bit_idx_q < 4'(DATA_BITS)) begin
            bus_out_d = data_q[bit_idx_q[2:0]];
        end
`ifdef BIDIR_XCVR_PARITY_EN
        else if (bit_idx_q == 4'(DATA_BITS)) begin
            bus_out_d = even_parity(data_q);
        end
`endif
    end

`ifdef BIDIR_XCVR_PARITY_EN
    assign rx_ok = (rx_bit == STOP_BIT) && (par_q == even_parity(data_q));
`else
    assign rx_ok = (rx_bit == STOP_BIT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            rx_data_q   <= '0;
            rx_expect_q <= 1'b0;
            bus_oe_q    <= 1'b0;
            bus_out_q   <= BUS_IDLE;
            rx_valid_q  <= 1'b0;
            rx_err_q    <= 1'b0;
            timeout_q   <= 1'b0;
            bit_idx_q   <= '0;
            to_q        <= '0;
`ifdef BIDIR_XCVR_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        data_q      <= tx_data;
                        rx_expect_q <= rx_expect;
                        bus_oe_q    <= 1'b1;
                        bus_out_q   <= START_BIT;
                        bit_idx_q   <= '0;
                        to_q        <= '0;
                        state_q     <= TX;
                    end
                end
                TX: begin
                    if (tmr_tick) begin
                        if (bit_idx_q == TX_STOP_IDX) begin
                            bus_oe_q  <= 1'b0;
                            bus_out_q <= BUS_IDLE;
                            bit_idx_q <= '0;
                            to_q      <= '0;
                            state_q   <= bidir_pkg::TURN;
                        end else begin
                            bus_out_q <= bus_out_d;
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end
                end
                bidir_pkg::TURN: begin
                    if (to_q == TURN_M1) begin
                        to_q    <= '0;
                        state_q <= rx_expect_q ? RX_WAIT : IDLE;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                RX_WAIT: begin
                    if (!rx_bit) begin
                        to_q    <= to_q + TO_W'(1);
                        state_q <= RX_START;
                    end else if (to_q >= TO_LAST) begin
                        timeout_q <= 1'b1;
                        to_q      <= '0;
                        state_q   <= IDLE;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                RX_START: begin
                    // The timeout budget keeps draining here so a glitch cannot extend it.
                    if (to_q < TO_LAST) begin
                        to_q <= to_q + TO_W'(1);
                    end
                    if (tmr_tick) begin
                        if (!rx_bit) begin
                            bit_idx_q <= '0;
                            state_q   <= RX_SHIFT;
                        end else begin
                            state_q <= RX_WAIT;
                        end
                    end
                end
                RX_SHIFT: begin
                    if (tmr_tick) begin
                        if (bit_idx_q < 4'(DATA_BITS)) begin
                            data_q    <= {rx_bit, data_q[DATA_BITS-1:1]};
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
`ifdef BIDIR_XCVR_PARITY_EN
                        else if (bit_idx_q == 4'(DATA_BITS)) begin
                            par_q     <= rx_bit;
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
`endif
                        else begin
                            if (rx_ok) begin
                                rx_data_q  <= data_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                rx_err_q <= 1'b1;
                            end
                            bit_idx_q <= '0;
                            to_q      <= '0;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign bus_oe   = bus_oe_q;
    assign bus_out  = bus_oe_q ? bus_out_q : BUS_IDLE;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_bidir_serial_xcvr.sv
// Directed bench for bidir_serial_xcvr: TX framing, reply reception, bad stop, glitch/timeout, mid-frame reset.
// Parity vectors are added when BIDIR_XCVR_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_bidir_serial_xcvr;

    localparam int DIV     = 16;
    localparam int TURN    = 4;
    localparam int TIMEOUT = 1024;
`ifdef BIDIR_XCVR_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] txData = 8'h00;
    logic       txValid = 1'b0;
    logic       rxExpect = 1'b0;
    logic       txReady;
    logic       busOe;
    logic       busOut;
    logic       busIn;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxErr;
    logic       timeoutPulse;
    logic       busy;
    logic       replyLine = 1'b1;
    logic       rxWindow = 1'b0;

    int total = 0;
    int bad = 0;
    int rxValidCnt = 0;
    int rxErrCnt = 0;
    int timeoutCnt = 0;
    int oeInRx = 0;
    int cycleCnt = 0;

    bidir_serial_xcvr #(
        .DIV(DIV),
        .TURN(TURN),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (txData),
        .tx_valid (txValid),
        .rx_expect(rxExpect),
        .tx_ready (txReady),
        .bus_oe   (busOe),
        .bus_out  (busOut),
        .bus_in   (busIn),
        .rx_data  (rxData),
        .rx_valid (rxValid),
        .rx_err   (rxErr),
        .timeout  (timeoutPulse),
        .busy     (busy)
    );

    // Pad model: the wire reads back our own drive, otherwise the remote end.
    assign busIn = busOe ? busOut : replyLine;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    always @(negedge clk) begin
        if (rxValid) rxValidCnt <= rxValidCnt + 1;
        if (rxErr) rxErrCnt <= rxErrCnt + 1;
        if (timeoutPulse) timeoutCnt <= timeoutCnt + 1;
        if (rxWindow && busOe) oeInRx <= oeInRx + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic frameBit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
`ifdef BIDIR_XCVR_PARITY_EN
        if (i == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input logic expectReply);
        @(negedge clk);
        txData = d;
        rxExpect = expectReply;
        txValid = 1'b1;
        @(posedge clk);
        #1 txValid = 1'b0;
    endtask

    // Samples first and last cycle of every bit; returns at the first negedge after the frame.
    task automatic checkTxFrame(input logic [7:0] d, input string tag);
        int oeCnt;
        oeCnt = 0;
        for (int i = 0; i < FRAME_BITS * DIV; i++) begin
            @(negedge clk);
            if (busOe) oeCnt++;
            if ((i % DIV == 0) || (i % DIV == DIV - 1))
                checkOutput(tag, {31'd0, busOut}, {31'd0, frameBit(d, i / DIV)});
        end
        @(negedge clk);
        checkOutput("oe_release", {31'd0, busOe}, 32'd0);
        checkOutput("oe_cycles", oeCnt, FRAME_BITS * DIV);
    endtask

    task automatic checkTurn(input logic expectReply);
        checkOutput("turn_ready0", {31'd0, txReady}, 32'd0);
        repeat (TURN - 1) @(negedge clk);
        checkOutput("turn_ready_last", {31'd0, txReady}, 32'd0);
        @(negedge clk);
        checkOutput("turn_exit_ready", {31'd0, txReady}, {31'd0, !expectReply});
    endtask

    task automatic sendReply(input logic [7:0] d, input logic par, input logic stopB);
        logic [10:0] bits;
`ifdef BIDIR_XCVR_PARITY_EN
        bits = {stopB, par, d, 1'b0};
`else
        bits = {par, stopB, d, 1'b0};
`endif
        for (int k = 0; k < FRAME_BITS; k++) begin
            replyLine = bits[k];
            repeat (DIV) @(posedge clk);
            #1;
        end
        replyLine = 1'b1;
    endtask

    task automatic doReply(input logic [7:0] txByte, input logic [7:0] reply,
                           input logic par, input logic stopB, input string tag);
        applyStimulus(txByte, 1'b1);
        checkTxFrame(txByte, tag);
        checkTurn(1'b1);
        rxWindow = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        sendReply(reply, par, stopB);
        repeat (3) @(negedge clk);
        rxWindow = 1'b0;
    endtask

    initial begin
        int v0;
        int e0;
        int entryCyc;
        int seenCyc;
        logic seen;

        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkOutput("rst_oe", {31'd0, busOe}, 32'd0);
        checkOutput("rst_out", {31'd0, busOut}, 32'd1);
        checkOutput("rst_ready", {31'd0, txReady}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_rxdata", {24'd0, rxData}, 32'h00);
        checkOutput("rst_rxvalid", {31'd0, rxValid}, 32'd0);
        checkOutput("rst_rxerr", {31'd0, rxErr}, 32'd0);
        checkOutput("rst_timeout", {31'd0, timeoutPulse}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // TX only, A5 -> 0,1,0,1,0,0,1,0,1,1
        applyStimulus(8'hA5, 1'b0);
        checkTxFrame(8'hA5, "tx_a5_bit");
        checkTurn(1'b0);

        // Good reply 5A after sending 3C.
        v0 = rxValidCnt;
        e0 = rxErrCnt;
        doReply(8'h3C, 8'h5A, 1'b0, 1'b1, "tx_3c_bit");
        checkOutput("rx5a_valid_pulses", rxValidCnt - v0, 1);
        checkOutput("rx5a_err_pulses", rxErrCnt - e0, 0);
        checkOutput("rx5a_data", {24'd0, rxData}, 32'h5A);
        checkOutput("rx5a_oe_during_rx", oeInRx, 0);
        checkOutput("rx5a_idle_after", {31'd0, txReady}, 32'd1);

        // Bad stop bit on reply FF.
        v0 = rxValidCnt;
        e0 = rxErrCnt;
        doReply(8'h81, 8'hFF, 1'b0, 1'b0, "tx_81_bit");
        checkOutput("badstop_err_pulses", rxErrCnt - e0, 1);
        checkOutput("badstop_valid_pulses", rxValidCnt - v0, 0);
        checkOutput("badstop_data_held", {24'd0, rxData}, 32'h5A);
        repeat (DIV) @(negedge clk);

        // Glitch in RX_WAIT, then timeout.
        v0 = rxValidCnt;
        e0 = timeoutCnt;
        applyStimulus(8'h55, 1'b1);
        checkTxFrame(8'h55, "tx_55_bit");
        checkTurn(1'b1);
        entryCyc = cycleCnt;
        repeat (10) @(posedge clk);
        #1 replyLine = 1'b0;
        repeat (3) @(posedge clk);
        #1 replyLine = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("glitch_busy", {31'd0, busy}, 32'd1);
        checkOutput("glitch_no_valid", rxValidCnt - v0, 0);
        checkOutput("glitch_no_timeout", timeoutCnt - e0, 0);
        seen = 1'b0;
        seenCyc = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (timeoutPulse) begin
                seen = 1'b1;
                seenCyc = cycleCnt;
            end
        end
        checkOutput("timeout_seen", {31'd0, seen}, 32'd1);
        checkOutput("timeout_latency", seenCyc - entryCyc, TIMEOUT);
        @(negedge clk);
        checkOutput("timeout_one_cycle", {31'd0, timeoutPulse}, 32'd0);
        checkOutput("timeout_idle", {31'd0, txReady}, 32'd1);

        // Asynchronous reset during d[3] of 00.
        applyStimulus(8'h00, 1'b0);
        repeat (70) @(negedge clk);
        checkOutput("prerst_oe", {31'd0, busOe}, 32'd1);
        checkOutput("prerst_out", {31'd0, busOut}, 32'd0);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_oe", {31'd0, busOe}, 32'd0);
        checkOutput("midrst_out", {31'd0, busOut}, 32'd1);
        checkOutput("midrst_ready", {31'd0, txReady}, 32'd1);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_rxdata", {24'd0, rxData}, 32'h00);
        @(negedge clk);
        applyStimulus(8'h01, 1'b0);
        checkTxFrame(8'h01, "tx_01_bit");
        checkTurn(1'b0);

`ifdef BIDIR_XCVR_PARITY_EN
        // 07 carries parity 1; reply 03 with parity 1 is a mismatch.
        v0 = rxValidCnt;
        e0 = rxErrCnt;
        doReply(8'h07, 8'h03, 1'b1, 1'b1, "tx_07_bit");
        checkOutput("par_err_pulses", rxErrCnt - e0, 1);
        checkOutput("par_valid_pulses", rxValidCnt - v0, 0);
        checkOutput("par_data_held", {24'd0, rxData}, 32'h00);
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
